// File: rtl/meas_uart_framer_if.sv
// Byte stream from the measurement framer to the UART transmitter.
// Master drives data/valid and holds them until ready completes the transfer.
interface meas_uart_framer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/meas_uart_framer.sv
// Packs pinlv/cycle/duty snapshots into 16-byte frames (AA 55 seq 3xBE32 chk)
// for the UART; a one-deep shadow absorbs strobes that land mid-frame.
module meas_uart_framer #(
  parameter logic [7:0] HDR0 = 8'hAA,
  parameter logic [7:0] HDR1 = 8'h55
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        i_pinlv,
  input  logic [31:0]        i_cycle,
  input  logic [31:0]        i_duty_cycle,
  input  logic               i_meas_valid,
  meas_uart_framer_if.master tx,
  output logic               o_busy,
  output logic [7:0]         o_seq,
  output logic [7:0]         o_ovf_cnt
);

  localparam int unsigned FRAME_LEN = 16;
  localparam logic [3:0]  LAST_IDX  = 4'(FRAME_LEN - 1);

  typedef struct packed {
    logic [31:0] pinlv;
    logic [31:0] cycle;
    logic [31:0] duty;
  } meas_t;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t     r_state, w_nxt_state;
  meas_t      r_frame, r_shadow;
  logic       r_pend;
  logic [3:0] r_idx;
  logic [7:0] r_seq;
  logic [7:0] r_ovf;

  meas_t      w_snap;
  logic       w_xfer, w_last;
  logic       w_load_live, w_load_shadow;
  logic [7:0] w_byte, w_chk;

  assign w_snap        = {i_pinlv, i_cycle, i_duty_cycle};
  assign w_xfer        = (r_state == S_SEND) && tx.tx_ready;
  assign w_last        = w_xfer && (r_idx == LAST_IDX);
  // Live inputs always beat a pending shadow when both are available in IDLE.
  assign w_load_live   = (r_state == S_IDLE) && i_meas_valid;
  assign w_load_shadow = (r_state == S_IDLE) && !i_meas_valid && r_pend;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_nxt_state = r_state;
    unique case (r_state)
      S_IDLE: if (i_meas_valid || r_pend) w_nxt_state = S_SEND;
      S_SEND: if (w_last)                 w_nxt_state = S_IDLE;
      default:                            w_nxt_state = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    o_busy      = 1'b0;
    if (r_state == S_SEND) begin
      tx.tx_valid = 1'b1;
      tx.tx_data  = w_byte;
      o_busy      = 1'b1;
    end
  end

  // ---------------- frame / shadow / counters ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame  <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_idx    <= '0;
      r_seq    <= '0;
      r_ovf    <= '0;
    end else begin
      if (w_load_live)        r_frame <= w_snap;
      else if (w_load_shadow) r_frame <= r_shadow;

      if ((r_state == S_SEND) && i_meas_valid) begin
        r_shadow <= w_snap;
        r_pend   <= 1'b1;
      end else if ((r_state == S_IDLE) && (i_meas_valid || r_pend)) begin
        r_pend   <= 1'b0;
      end

      if (w_xfer) r_idx <= w_last ? 4'd0 : r_idx + 4'd1;
      if (w_last) r_seq <= r_seq + 8'd1;

      // A strobe with a pending snapshot always discards one snapshot.
      if (i_meas_valid && r_pend && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
    end
  end

  // Checksum over seq and the 12 frozen payload bytes.
  always_comb begin
    w_chk = r_seq;
    for (int i = 0; i < 4; i++) begin
      w_chk = w_chk + r_frame.pinlv[8*i +: 8] + r_frame.cycle[8*i +: 8]
                    + r_frame.duty[8*i +: 8];
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0:  w_byte = HDR0;
      4'd1:  w_byte = HDR1;
      4'd2:  w_byte = r_seq;
      4'd3:  w_byte = r_frame.pinlv[31:24];
      4'd4:  w_byte = r_frame.pinlv[23:16];
      4'd5:  w_byte = r_frame.pinlv[15:8];
      4'd6:  w_byte = r_frame.pinlv[7:0];
      4'd7:  w_byte = r_frame.cycle[31:24];
      4'd8:  w_byte = r_frame.cycle[23:16];
      4'd9:  w_byte = r_frame.cycle[15:8];
      4'd10: w_byte = r_frame.cycle[7:0];
      4'd11: w_byte = r_frame.duty[31:24];
      4'd12: w_byte = r_frame.duty[23:16];
      4'd13: w_byte = r_frame.duty[15:8];
      4'd14: w_byte = r_frame.duty[7:0];
      4'd15: w_byte = w_chk;
      default: w_byte = 8'h00;
    endcase
  end

  assign o_seq     = r_seq;
  assign o_ovf_cnt = r_ovf;

endmodule

// File: tb/tb_meas_uart_framer.sv
// Self-checking bench: frame-level queue model compared every cycle, plus
// literal expectations for the directed scenarios.
module tb_meas_uart_framer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pinlv = '0, cyc_in = '0, duty = '0;
  logic        meas_valid = 1'b0;
  logic        busy;
  logic [7:0]  seq, ovf;

  meas_uart_framer_if txi();

  meas_uart_framer dut (
    .clk          (clk),
    .rst          (rst),
    .i_pinlv      (pinlv),
    .i_cycle      (cyc_in),
    .i_duty_cycle (duty),
    .i_meas_valid (meas_valid),
    .tx           (txi),
    .o_busy       (busy),
    .o_seq        (seq),
    .o_ovf_cnt    (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, nprint = 0, ncyc = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (nprint < 40) begin
        nprint++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ncyc);
      end
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0]  q[$];
  logic        m_busy = 1'b0, m_pend = 1'b0, started = 1'b0;
  logic [7:0]  m_seq = '0, m_ovf = '0;
  logic [31:0] m_sp, m_sc, m_sd;

  task automatic load(input logic [31:0] p, input logic [31:0] c, input logic [31:0] d);
    logic [31:0] w [3];
    logic [7:0]  s;
    w[0] = p; w[1] = c; w[2] = d;
    q.delete();
    q.push_back(8'hAA); q.push_back(8'h55); q.push_back(m_seq);
    for (int i = 0; i < 3; i++)
      for (int k = 3; k >= 0; k--) q.push_back(w[i][8*k +: 8]);
    s = 8'h00;
    for (int i = 2; i < 15; i++) s = s + q[i];
    q.push_back(s);
    m_busy = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_pend = 1'b0; m_seq = '0; m_ovf = '0; q.delete(); started = 1'b1;
    end else if (m_busy) begin
      if (meas_valid) begin
        if (m_pend && m_ovf != 8'hFF) m_ovf = m_ovf + 8'd1;
        m_pend = 1'b1; m_sp = pinlv; m_sc = cyc_in; m_sd = duty;
      end
      if (txi.tx_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) begin m_busy = 1'b0; m_seq = m_seq + 8'd1; end
      end
    end else begin
      if (meas_valid) begin
        if (m_pend && m_ovf != 8'hFF) m_ovf = m_ovf + 8'd1;
        m_pend = 1'b0;
        load(pinlv, cyc_in, duty);
      end else if (m_pend) begin
        m_pend = 1'b0;
        load(m_sp, m_sc, m_sd);
      end
    end
  end

  // ---------------- per-cycle compare + transfer log ----------------
  logic [7:0] got[$];
  int         got_cyc[$];
  int         dpos = 0, nframes = 0;
  logic [7:0] last_seqb = '0;

  always @(negedge clk) begin
    if (started) begin
      ncyc++;
      chk("tx_valid", txi.tx_valid, m_busy);
      chk("tx_data",  txi.tx_data,  m_busy ? q[0] : 8'h00);
      chk("busy",     busy,         m_busy);
      chk("seq",      seq,          m_seq);
      chk("ovf_cnt",  ovf,          m_ovf);
      if (rst) dpos = 0;
      else if (txi.tx_valid && txi.tx_ready) begin
        got.push_back(txi.tx_data);
        got_cyc.push_back(ncyc);
        if (dpos == 2) last_seqb = txi.tx_data;
        if (dpos == 15) begin dpos = 0; nframes++; end
        else dpos++;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] t1 [16] = '{8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h13, 8'h88, 8'h00,
                          8'h00, 8'h4E, 8'h20, 8'h00, 8'h00, 8'h00, 8'h32, 8'h3B};

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic [31:0] p, input logic [31:0] c, input logic [31:0] d);
    pinlv = p; cyc_in = c; duty = d; meas_valid = 1'b1;
    cyc();
    meas_valid = 1'b0;
    pinlv = $urandom; cyc_in = $urandom; duty = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  task automatic run_until_idle(input int maxc, input bit rnd);
    int n = 0;
    txi.tx_ready = 1'b1;
    while ((busy || m_busy || m_pend) && n < maxc) begin
      if (rnd) txi.tx_ready = 1'($urandom_range(0, 1));
      cyc();
      n++;
    end
    txi.tx_ready = 1'b1;
    if (n >= maxc) chk("idle_timeout", 32'(n), 32'(maxc - 1));
  endtask

  initial begin
    logic [7:0] e2 [16];
    int n;
    txi.tx_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_valid", txi.tx_valid, 0);
    chk("rst_data",  txi.tx_data,  0);
    chk("rst_busy",  busy, 0);
    chk("rst_seq",   seq,  0);
    chk("rst_ovf",   ovf,  0);
    rst = 1'b0; cyc();

    // Basic frame
    got.delete(); got_cyc.delete();
    strobe(32'h00001388, 32'h00004E20, 32'h00000032);
    chk("t1_latency", txi.tx_valid, 1);
    run_until_idle(100, 1'b0);
    chk("t1_len", got.size(), 16);
    if (got.size() >= 16) begin
      for (int i = 0; i < 16; i++) chk($sformatf("t1_byte%0d", i), got[i], t1[i]);
      chk("t1_consec", 32'(got_cyc[15] - got_cyc[0]), 15);
    end
    chk("t1_seq", seq, 1);

    // Backpressure: same payload, seq 1, checksum bumps by one
    got.delete();
    for (int i = 0; i < 16; i++) e2[i] = t1[i];
    e2[2] = 8'h01; e2[15] = 8'h3C;
    strobe(32'h00001388, 32'h00004E20, 32'h00000032);
    run_until_idle(500, 1'b1);
    chk("t2_len", got.size(), 16);
    if (got.size() >= 16)
      for (int i = 0; i < 16; i++) chk($sformatf("t2_byte%0d", i), got[i], e2[i]);

    // Strobes during SEND
    do_reset(); got.delete();
    strobe(32'h11223344, 32'h55667788, 32'h99AABBCC);
    cyc();
    strobe(32'd1, 32'd0, 32'd0);
    cyc();
    strobe(32'd2, 32'd0, 32'd0);
    run_until_idle(200, 1'b0);
    chk("t3_ovf", ovf, 1);
    chk("t3_len", got.size(), 32);
    if (got.size() >= 32) begin
      chk("t3_f0_seq", got[2], 8'h00);
      chk("t3_f0_pinlv", {got[3], got[4], got[5], got[6]}, 32'h11223344);
      chk("t3_f1_seq", got[18], 8'h01);
      chk("t3_f1_pinlv", {got[19], got[20], got[21], got[22]}, 32'd2);
    end

    // Overrun saturation and seq wrap
    do_reset();
    txi.tx_ready = 1'b0;
    strobe($urandom, $urandom, $urandom);
    for (int i = 0; i < 301; i++) begin
      strobe($urandom, $urandom, $urandom);
      cyc();
    end
    chk("t4_ovf_sat", ovf, 8'hFF);
    chk("t4_hold_data", txi.tx_data, 8'hAA);
    chk("t4_hold_valid", txi.tx_valid, 1);
    nframes = 0;
    run_until_idle(200, 1'b0);
    for (int i = 0; i < 254; i++) begin
      strobe($urandom, $urandom, $urandom);
      run_until_idle(100, 1'b0);
    end
    chk("t4_frames", nframes, 256);
    chk("t4_seq_wrap", seq, 0);
    chk("t4_last_seqb", last_seqb, 8'hFF);
    chk("t4_ovf_hold", ovf, 8'hFF);

    // Reset mid-frame at index 7 with a pending snapshot
    do_reset();
    strobe(32'hDEADBEEF, 32'h01020304, 32'h0A0B0C0D);
    txi.tx_ready = 1'b0;
    strobe(32'h12345678, 32'h0, 32'h0);
    txi.tx_ready = 1'b1;
    repeat (7) cyc();
    txi.tx_ready = 1'b0;
    chk("t5_pre_busy", busy, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    txi.tx_ready = 1'b1;
    chk("t5_valid", txi.tx_valid, 0);
    chk("t5_seq", seq, 0);
    repeat (5) cyc();
    chk("t5_no_pending", busy, 0);
    got.delete();
    strobe(32'h0, 32'h0, 32'h0);
    run_until_idle(100, 1'b0);
    chk("t5_len", got.size(), 16);
    if (got.size() >= 3) begin
      chk("t5_b0", got[0], 8'hAA);
      chk("t5_b1", got[1], 8'h55);
      chk("t5_b2", got[2], 8'h00);
    end

    // Strobe in the single IDLE cycle with pending set
    got.delete();
    strobe(32'hCAFE0001, 32'h1, 32'h1);
    cyc();
    strobe(32'hCAFE0002, 32'h2, 32'h2);
    n = 0;
    while (!(!m_busy && m_pend) && n < 100) begin cyc(); n++; end
    if (n >= 100) chk("t6_timeout", 32'(n), 0);
    chk("t6_dut_idle", busy, 0);
    strobe(32'hCAFE0003, 32'h3, 32'h3);
    run_until_idle(100, 1'b0);
    repeat (20) cyc();
    chk("t6_ovf", ovf, 1);
    chk("t6_len", got.size(), 32);
    chk("t6_busy", busy, 0);
    if (got.size() >= 32)
      chk("t6_live", {got[19], got[20], got[21], got[22]}, 32'hCAFE0003);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      pinlv = $urandom; cyc_in = $urandom; duty = $urandom;
      meas_valid = ($urandom_range(0, 14) == 0);
      txi.tx_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 599) == 0);
      cyc();
    end
    meas_valid = 1'b0; rst = 1'b0;
    run_until_idle(200, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
